// File: rtl/bcd_demux.sv
// Receive side of a time-multiplexed BCD display bus.
// Each digit slot must be held stable (select and data) for HOLD_MIN clocks
// before it is accepted; accepted slots are checked for select and BCD
// validity and for scan order, and a complete in-order scan (digit 0 first)
// is published as one packed BCD word.
//
// Ports:
//   clk_i          clock, rising edge
//   i_rst          asynchronous active-low reset
//   i_bcd_muxed    current digit value
//   i_bcd_sel      one-hot digit select, bit k = digit index k
//   o_bcd_data     last complete frame, digit 0 in the most significant nibble
//   o_frame_valid  one-cycle pulse when o_bcd_data is updated
//   o_sel_err      one-cycle pulse on an accepted multi-hot select
//   o_seq_err      one-cycle pulse on an out-of-order digit index
//   o_bcd_err      one-cycle pulse on an accepted nibble above 9
module bcd_demux #(
  parameter int unsigned DIS_NUM  = 4,
  parameter int unsigned HOLD_MIN = 4
) (
  input  logic                   clk_i,
  input  logic                   i_rst,
  input  logic [3:0]             i_bcd_muxed,
  input  logic [DIS_NUM-1:0]     i_bcd_sel,
  output logic [DIS_NUM*4-1:0]   o_bcd_data,
  output logic                   o_frame_valid,
  output logic                   o_sel_err,
  output logic                   o_seq_err,
  output logic                   o_bcd_err
);

  localparam int unsigned CntW = $clog2(HOLD_MIN + 1);
  localparam int unsigned IdxW = (DIS_NUM > 1) ? $clog2(DIS_NUM) : 1;
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_MIN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIS_NUM - 1);

  typedef enum logic [0:0] {StHunt, StAssemble} state_e;

  state_e                 state_q, state_d;
  logic [DIS_NUM-1:0]     sel_q;
  logic [3:0]             dat_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   acc_q, acc_d;
  logic [IdxW-1:0]        exp_q, exp_d;
  logic [DIS_NUM*4-1:0]   frame_q, frame_d;
  logic [DIS_NUM*4-1:0]   data_q, data_d;
  logic                   fv_q, fv_d;
  logic                   sel_err_q, sel_err_d;
  logic                   seq_err_q, seq_err_d;
  logic                   bcd_err_q, bcd_err_d;

  logic                   accept;
  logic                   blank;
  logic                   multi;
  logic [IdxW-1:0]        idx;
  logic [DIS_NUM*4-1:0]   frame_ins;    // partial frame with this nibble inserted
  logic [DIS_NUM*4-1:0]   frame_first;  // fresh frame holding only digit 0

  // Stability filter: a slot is accepted once, on the edge its hold count hits HOLD_MIN.
  always_comb begin
    blank  = (i_bcd_sel == '0);
    accept = 1'b0;
    if ((i_bcd_sel == sel_q) && (i_bcd_muxed == dat_q)) begin
      cnt_d = (cnt_q == HoldMax) ? cnt_q : cnt_q + CntW'(1);
      acc_d = acc_q;
    end else begin
      cnt_d = CntW'(1);
      acc_d = 1'b0;
    end
    if ((cnt_d == HoldMax) && !acc_d) begin
      acc_d  = 1'b1;
      accept = !blank;
    end
  end

  // Slot decode: multi-hot detect, digit index and nibble placement.
  always_comb begin
    multi       = !blank && ((i_bcd_sel & (i_bcd_sel - DIS_NUM'(1))) != '0);
    idx         = '0;
    frame_ins   = frame_q;
    frame_first = '0;
    frame_first[DIS_NUM*4-1 -: 4] = i_bcd_muxed;
    for (int k = 0; k < DIS_NUM; k++) begin
      if (i_bcd_sel[k]) begin
        idx = IdxW'(k);
        frame_ins[4*(DIS_NUM-1-k) +: 4] = i_bcd_muxed;
      end
    end
  end

  // Frame assembly; errors take priority over completion.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    frame_d   = frame_q;
    data_d    = data_q;
    fv_d      = 1'b0;
    sel_err_d = 1'b0;
    seq_err_d = 1'b0;
    bcd_err_d = 1'b0;
    if (accept) begin
      if (multi) begin
        sel_err_d = 1'b1;
        frame_d   = '0;
        exp_d     = '0;
        state_d   = StHunt;
      end else if (i_bcd_muxed > 4'd9) begin
        bcd_err_d = 1'b1;
        frame_d   = '0;
        exp_d     = '0;
        state_d   = StHunt;
      end else if (state_q == StHunt) begin
        if (idx == '0) begin
          state_d = StAssemble;
          if (DIS_NUM == 1) begin
            data_d  = frame_first;
            fv_d    = 1'b1;
            frame_d = '0;
            exp_d   = '0;
          end else begin
            frame_d = frame_first;
            exp_d   = IdxW'(1);
          end
        end
      end else if (idx == exp_q) begin
        if (idx == LastIdx) begin
          data_d  = frame_ins;
          fv_d    = 1'b1;
          frame_d = '0;
          exp_d   = '0;
        end else begin
          frame_d = frame_ins;
          exp_d   = exp_q + IdxW'(1);
        end
      end else begin
        seq_err_d = 1'b1;
        if (idx == '0) begin
          frame_d = frame_first;
          exp_d   = IdxW'(1);
        end else begin
          frame_d = '0;
          exp_d   = '0;
          state_d = StHunt;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= StHunt;
      sel_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      exp_q     <= '0;
      frame_q   <= '0;
      data_q    <= '0;
      fv_q      <= 1'b0;
      sel_err_q <= 1'b0;
      seq_err_q <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= i_bcd_sel;
      dat_q     <= i_bcd_muxed;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      exp_q     <= exp_d;
      frame_q   <= frame_d;
      data_q    <= data_d;
      fv_q      <= fv_d;
      sel_err_q <= sel_err_d;
      seq_err_q <= seq_err_d;
      bcd_err_q <= bcd_err_d;
    end
  end

  assign o_bcd_data    = data_q;
  assign o_frame_valid = fv_q;
  assign o_sel_err     = sel_err_q;
  assign o_seq_err     = seq_err_q;
  assign o_bcd_err     = bcd_err_q;

endmodule

// File: tb/tb_bcd_demux.sv
// Bench for bcd_demux: slot-level reference model feeding a scoreboard of
// expected output pulses (kind, edge number, data word); a negedge monitor
// pops and compares whenever the DUT raises any pulse.
module tb_bcd_demux;

  localparam int unsigned DN = 4;
  localparam int unsigned HM = 4;

  // Pulse kinds as the vector {frame_valid, sel_err, bcd_err, seq_err}.
  localparam logic [3:0] KFv  = 4'b1000;
  localparam logic [3:0] KSel = 4'b0100;
  localparam logic [3:0] KBcd = 4'b0010;
  localparam logic [3:0] KSeq = 4'b0001;

  typedef struct {
    int            at;
    logic [3:0]    kind;
    logic [DN*4-1:0] data;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [3:0]      bcd_muxed;
  logic [DN-1:0]   bcd_sel;
  logic [DN*4-1:0] bcd_data;
  logic            frame_valid;
  logic            sel_err;
  logic            seq_err;
  logic            bcd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t sb[$];

  // Reference model state (slot level).
  int              m_hunt;
  int              m_exp;
  int              m_parts[DN];
  logic [DN*4-1:0] m_data;
  logic [DN-1:0]   m_prev_sel;
  logic [3:0]      m_prev_dat;

  bcd_demux #(
    .DIS_NUM  (DN),
    .HOLD_MIN (HM)
  ) dut (
    .clk_i         (clk),
    .i_rst         (rst_n),
    .i_bcd_muxed   (bcd_muxed),
    .i_bcd_sel     (bcd_sel),
    .o_bcd_data    (bcd_data),
    .o_frame_valid (frame_valid),
    .o_sel_err     (sel_err),
    .o_seq_err     (seq_err),
    .o_bcd_err     (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void model_reset();
    m_hunt     = 1;
    m_exp      = 0;
    for (int k = 0; k < DN; k++) m_parts[k] = 0;
    m_data     = '0;
    m_prev_sel = '0;
    m_prev_dat = '0;
  endfunction

  function automatic void push(input logic [3:0] kind, input int at);
    exp_t e;
    e.at   = at;
    e.kind = kind;
    e.data = m_data;
    sb.push_back(e);
  endfunction

  // Effect of one accepted slot, straight from the protocol rules.
  function automatic void model_accept(input logic [DN-1:0] sel, input int dat, input int at);
    int idx = 0;
    for (int k = 0; k < DN; k++) if (sel[k]) idx = k;
    if ($countones(sel) > 1) begin
      m_hunt = 1;
      push(KSel, at);
    end else if (dat > 9) begin
      m_hunt = 1;
      push(KBcd, at);
    end else if (m_hunt != 0) begin
      if (idx == 0) begin
        m_parts[0] = dat;
        m_exp      = 1;
        m_hunt     = 0;
      end
    end else if (idx == m_exp) begin
      m_parts[idx] = dat;
      m_exp++;
      if (m_exp == DN) begin
        int word = 0;
        for (int k = 0; k < DN; k++) word = word * 16 + m_parts[k];
        m_data = word[DN*4-1:0];
        m_exp  = 0;
        push(KFv, at);
      end
    end else begin
      push(KSeq, at);
      if (idx == 0) begin
        m_parts[0] = dat;
        m_exp      = 1;
      end else begin
        m_hunt = 1;
      end
    end
  endfunction

  // Present one slot for len edges; caller keeps consecutive slots distinct.
  task automatic drive_slot(input logic [DN-1:0] sel, input logic [3:0] dat, input int len);
    bcd_sel   = sel;
    bcd_muxed = dat;
    if (sel != '0 && len >= HM) model_accept(sel, int'(dat), cyc + HM);
    m_prev_sel = sel;
    m_prev_dat = dat;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int d0, input int d1, input int d2, input int d3);
    drive_slot(4'b0001, d0[3:0], 10);
    drive_slot(4'b0010, d1[3:0], 10);
    drive_slot(4'b0100, d2[3:0], 10);
    drive_slot(4'b1000, d3[3:0], 10);
  endtask

  // Monitor: every pulse must match the head of the scoreboard in edge, kind and data.
  logic [3:0] mon_vec;
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].at < cyc) begin
        check("missing_pulse_kind", 32'd0, 32'(sb[0].kind));
        void'(sb.pop_front());
      end
      mon_vec = {frame_valid, sel_err, bcd_err, seq_err};
      if (mon_vec != 4'b0000) begin
        if (sb.size() == 0 || sb[0].at != cyc) begin
          check("unexpected_pulse", 32'(mon_vec), 32'd0);
        end else begin
          check("pulse_kind", 32'(mon_vec), 32'(sb[0].kind));
          check("pulse_data", 32'(bcd_data), 32'(sb[0].data));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DN-1:0] rsel;
    logic [3:0]    rdat;
    int            rlen;
    int            gidx;
    int            a;
    int            r;

    rst_n     = 1'b0;
    bcd_sel   = '0;
    bcd_muxed = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(bcd_data), 32'd0);
    check("reset_fv", 32'(frame_valid), 32'd0);
    check("reset_sel_err", 32'(sel_err), 32'd0);
    check("reset_seq_err", 32'(seq_err), 32'd0);
    check("reset_bcd_err", 32'(bcd_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_slot('0, 4'd0, 5);

    // Stream starting mid-scan: slots 2,3 dropped in hunt, then 5678.
    drive_slot(4'b0100, 4'd3, 10);
    drive_slot(4'b1000, 4'd4, 10);
    frame(5, 6, 7, 8);

    // Two back-to-back scans, one pulse each.
    frame(1, 2, 3, 4);
    frame(1, 2, 3, 4);

    // Shortened slot 1 is never accepted; slot 2 is out of order.
    drive_slot(4'b0001, 4'd3, 10);
    drive_slot(4'b0010, 4'd4, 2);
    drive_slot(4'b0100, 4'd5, 10);
    drive_slot(4'b1000, 4'd6, 10);
    frame(9, 0, 1, 2);

    // Multi-hot select, then a non-BCD nibble inside a frame.
    drive_slot(4'b0011, 4'd1, 10);
    drive_slot(4'b0001, 4'd1, 10);
    drive_slot(4'b0010, 4'd2, 10);
    drive_slot(4'b0100, 4'hA, 10);
    drive_slot(4'b1000, 4'd4, 10);

    // Blank gaps between slots.
    drive_slot(4'b0001, 4'd8, 10);
    drive_slot('0, 4'd0, 6);
    drive_slot(4'b0010, 4'd7, 10);
    drive_slot('0, 4'd0, 6);
    drive_slot(4'b0100, 4'd6, 10);
    drive_slot('0, 4'd0, 6);
    drive_slot(4'b1000, 4'd5, 10);
    drive_slot('0, 4'd0, 6);

    // Reset pulse in the middle of slot 2.
    drive_slot(4'b0001, 4'd3, 10);
    drive_slot(4'b0010, 4'd1, 10);
    bcd_sel   = 4'b0100;
    bcd_muxed = 4'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_data", 32'(bcd_data), 32'd0);
    check("midreset_fv", 32'(frame_valid), 32'd0);
    check("midreset_errs", 32'({sel_err, bcd_err, seq_err}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_slot(4'b0100, 4'd7, 8);
    drive_slot(4'b1000, 4'd2, 10);
    frame(4, 3, 2, 1);

    // Randomized scans with mostly in-order digits and occasional faults.
    gidx = 0;
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        rsel = '0;
      end else if (r < 13) begin
        a    = int'($urandom_range(0, DN - 1));
        rsel = DN'(1) << a;
        rsel = rsel | (DN'(1) << ((a + 1 + int'($urandom_range(0, DN - 2))) % DN));
      end else begin
        if ($urandom_range(0, 99) < 85) gidx = (gidx + 1) % DN;
        else gidx = int'($urandom_range(0, DN - 1));
        rsel = DN'(1) << gidx;
      end
      rdat = ($urandom_range(0, 99) < 92) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      rlen = ($urandom_range(0, 9) < 8) ? int'($urandom_range(HM, 10)) : int'($urandom_range(1, HM - 1));
      if (rsel == m_prev_sel && rdat == m_prev_dat) rdat = rdat ^ 4'h1;
      drive_slot(rsel, rdat, rlen);
    end
    if (m_prev_sel == '0 && m_prev_dat == 4'd0) drive_slot('0, 4'd1, 10);
    else drive_slot('0, 4'd0, 10);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_demux.md
Name: bcd_demux

Overview:
- Receive side of the time-multiplexed BCD display bus: inputs are a 4-bit muxed digit and a one-hot digit select. The bus is scanned at a fixed rate, so each digit slot is held for many clocks.
- The block filters slot glitches, checks select and sequence integrity, and reassembles the parallel packed BCD word.
- Uses: display-bus monitoring, loopback self-test, and bridging a scanned display bus back into register space.

Parameters:
- DIS_NUM, 4: number of digits; packed data width is DIS_NUM*4.
- HOLD_MIN, 4: consecutive identical samples (select and data) required before a slot is accepted; must be ≥1.

Ports:
- clk_i  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_bcd_muxed  input  4  current digit value.
- i_bcd_sel  input  DIS_NUM  one-hot digit select; bit k is digit index k.
- o_bcd_data  output  DIS_NUM*4  last complete frame; digit k at bits [4*(DIS_NUM-1-k)+:4], so digit 0 is the MS nibble.
- o_frame_valid  output  1  one-cycle pulse when o_bcd_data is updated.
- o_sel_err  output  1  one-cycle pulse on an accepted multi-hot select.
- o_seq_err  output  1  one-cycle pulse on an out-of-order digit index.
- o_bcd_err  output  1  one-cycle pulse on an accepted nibble > 9.

Behaviour:
- Reset (async, i_rst=0): all outputs 0, partial-frame register 0, hold counter 0, FSM=HUNT, expected index 0, accepted flag 0.
- Sample registers: r_sel and r_dat capture the inputs on every edge.
- Hold counter, width clogb2(HOLD_MIN+1), saturates at HOLD_MIN:
  - If the inputs equal r_sel/r_dat, it increments.
  - Otherwise it loads 1 and clears the accepted flag.
- Acceptance: a slot is accepted on the edge where the counter reaches HOLD_MIN (or on the first new-value edge when HOLD_MIN=1) while the accepted flag is 0. The flag is then set, so one slot is accepted once, however long it is held.
- All-zero select: a blank slot. It is never accepted, raises no error and does not change FSM state.
- Multi-hot select accepted: pulse o_sel_err, discard the partial frame, go to HUNT.
- Accepted nibble > 9: pulse o_bcd_err, discard the partial frame, go to HUNT.
- FSM states:
  - HUNT: wait for an accepted valid slot with index 0. On it, store the nibble, set expected=1, go to ASSEMBLE (or complete immediately if DIS_NUM=1). Any other accepted index is dropped silently.
  - ASSEMBLE, accepted index == expected: store the nibble and increment expected.
  - ASSEMBLE, accepted index == expected and index == DIS_NUM-1: on that same edge, load o_bcd_data with the full frame, pulse o_frame_valid, set expected=0 and stay in ASSEMBLE.
  - ASSEMBLE, accepted index ≠ expected: pulse o_seq_err and discard the partial frame. If the index is 0, restart the frame (store nibble, expected=1); otherwise go to HUNT.
- Latency: o_frame_valid and the new o_bcd_data are visible after the edge on which the last digit is accepted, i.e. (HOLD_MIN-1) cycles after that digit first appears.
- Simultaneous events: an error has priority over completion. The error pulses are mutually exclusive, with o_sel_err > o_bcd_err > o_seq_err.
- o_bcd_data holds its value between frames and is never partially updated.
- A reset assertion mid-frame clears everything immediately; the next frame must start from index 0 via HUNT.

Test Plan:
- DIS_NUM=4, HOLD_MIN=4. Slots of 10 cycles: sel 0001/0010/0100/1000 with data 1/2/3/4 → o_bcd_data=16'h1234, a single o_frame_valid pulse 3 cycles into slot 3. A repeated scan gives one pulse per frame.
- Start the stream at slot 2 (data 3), then a full 5/6/7/8 scan → no pulse and no error for slots 2–3; then o_bcd_data=16'h5678.
- Slot 1 shortened to 2 cycles → slot 1 not accepted; slot 2 gives o_seq_err and HUNT; the following full frame 9/0/1/2 → 16'h9012.
- Accepted sel=4'b0011 → o_sel_err pulse, o_bcd_data unchanged. Accepted nibble 4'hA at slot 2 → o_bcd_err pulse, no frame_valid for that frame.
- Insert 6-cycle sel=0000 gaps between slots of an 8/7/6/5 frame → o_bcd_data=16'h8765, no errors.
- Assert i_rst for 1 cycle during slot 2 → all outputs 0 asynchronously; the rest of that frame is ignored; the next full frame loads correctly.
